// File: rtl/dvp_pixel_tx.sv
`default_nettype none
// ============================================================================
// Module   : dvp_pixel_tx
// Purpose  : DVP camera-side transmitter: vs/href/8-bit RGB565 byte stream,
//            fed from a ready/valid pixel stream or internal 8-bar pattern.
// Revision : 1.0
// ============================================================================
module dvp_pixel_tx #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int H_BLANK  = 144,
    parameter int VS_PULSE = 3,
    parameter int V_FRONT  = 10,
    parameter int V_BACK   = 10
) (
    input  logic        pclk_in,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        pattern_sel,
    input  logic [15:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        vs_out,
    output logic        href_out,
    output logic [7:0]  data_out,
    output logic        frame_done,
    output logic        underrun
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_VSYNC  = 3'd1;
    localparam logic [2:0] S_VFRONT = 3'd2;
    localparam logic [2:0] S_ACTIVE = 3'd3;
    localparam logic [2:0] S_HBLANK = 3'd4;
    localparam logic [2:0] S_VBACK  = 3'd5;

    localparam logic [15:0] C_VS_LAST   = 16'(VS_PULSE - 1);
    localparam logic [15:0] C_VF_LAST   = 16'(V_FRONT - 1);
    localparam logic [15:0] C_LINE_LAST = 16'(2 * H_ACTIVE - 1);
    localparam logic [15:0] C_HB_LAST   = 16'(H_BLANK - 1);
    localparam logic [15:0] C_VB_LAST   = 16'(V_BACK - 1);
    localparam logic [15:0] C_LAST_ROW  = 16'(V_ACTIVE - 1);
    localparam logic [15:0] C_BAR_LAST  = 16'(H_ACTIVE / 8 - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_next;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_next;
    logic [15:0] r_line;
    logic [15:0] w_line_next;

    logic        r_pattern;
    logic [2:0]  r_bar_idx;
    logic [15:0] r_bar_px;
    logic [7:0]  r_low;

    logic        r_vs;
    logic        r_href;
    logic [7:0]  r_data;
    logic        r_done;
    logic        r_underrun;

    logic        w_load;
    logic        w_start_frame;
    logic [2:0]  w_cur_bar;
    logic [15:0] w_cur_px;
    logic [15:0] w_bar_color;
    logic [15:0] w_pixel;
    logic [7:0]  w_data_next;

    // State register: r_cnt counts cycles spent in the current state.
    always_ff @(posedge pclk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_line  <= 16'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_line  <= w_line_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt + 16'd1;
        w_line_next  = r_line;
        case (r_state)
            S_IDLE: begin
                w_cnt_next  = 16'd0;
                w_line_next = 16'd0;
                if (enable) w_state_next = S_VSYNC;
            end
            S_VSYNC: begin
                if (r_cnt == C_VS_LAST) begin
                    w_state_next = S_VFRONT;
                    w_cnt_next   = 16'd0;
                end
            end
            S_VFRONT: begin
                if (r_cnt == C_VF_LAST) begin
                    w_state_next = S_ACTIVE;
                    w_cnt_next   = 16'd0;
                    w_line_next  = 16'd0;
                end
            end
            S_ACTIVE: begin
                if (r_cnt == C_LINE_LAST) begin
                    w_state_next = (r_line == C_LAST_ROW) ? S_VBACK : S_HBLANK;
                    w_cnt_next   = 16'd0;
                end
            end
            S_HBLANK: begin
                if (r_cnt == C_HB_LAST) begin
                    w_state_next = S_ACTIVE;
                    w_cnt_next   = 16'd0;
                    w_line_next  = r_line + 16'd1;
                end
            end
            S_VBACK: begin
                if (r_cnt == C_VB_LAST) begin
                    w_state_next = enable ? S_VSYNC : S_IDLE;
                    w_cnt_next   = 16'd0;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = 16'd0;
                w_line_next  = 16'd0;
            end
        endcase
    end

    // Outputs are registered from next-state values, so a pixel slot is the
    // cycle before the high byte is on the bus.
    always_comb begin
        w_load        = (w_state_next == S_ACTIVE) && !w_cnt_next[0];
        w_start_frame = (w_state_next == S_VSYNC) && (r_state != S_VSYNC);
        w_cur_bar     = (w_cnt_next == 16'd0) ? 3'd0 : r_bar_idx;
        w_cur_px      = (w_cnt_next == 16'd0) ? 16'd0 : r_bar_px;
        w_bar_color   = 16'h0000;
        case (w_cur_bar)
            3'd0:    w_bar_color = 16'hFFFF;
            3'd1:    w_bar_color = 16'hFFE0;
            3'd2:    w_bar_color = 16'h07FF;
            3'd3:    w_bar_color = 16'h07E0;
            3'd4:    w_bar_color = 16'hF81F;
            3'd5:    w_bar_color = 16'hF800;
            3'd6:    w_bar_color = 16'h001F;
            default: w_bar_color = 16'h0000;
        endcase
        w_pixel     = r_pattern ? w_bar_color : (pix_valid ? pix_data : 16'h0000);
        w_data_next = 8'h00;
        if (w_state_next == S_ACTIVE) begin
            w_data_next = w_cnt_next[0] ? r_low : w_pixel[15:8];
        end
        pix_ready = w_load && !r_pattern;
    end

    always_ff @(posedge pclk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_vs       <= 1'b0;
            r_href     <= 1'b0;
            r_data     <= 8'h00;
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            r_pattern  <= 1'b0;
            r_bar_idx  <= 3'd0;
            r_bar_px   <= 16'd0;
            r_low      <= 8'h00;
        end else begin
            r_vs   <= (w_state_next == S_VSYNC);
            r_href <= (w_state_next == S_ACTIVE);
            r_data <= w_data_next;
            r_done <= (w_state_next == S_VBACK) && (w_cnt_next == C_VB_LAST);
            if (w_start_frame) r_pattern <= pattern_sel;
            if (pix_ready && !pix_valid) r_underrun <= 1'b1;
            if (w_load) begin
                r_low <= w_pixel[7:0];
                // Bar 7 saturates and absorbs any remainder pixels.
                if (w_cur_bar == 3'd7) begin
                    r_bar_idx <= 3'd7;
                    r_bar_px  <= w_cur_px;
                end else if (w_cur_px == C_BAR_LAST) begin
                    r_bar_idx <= w_cur_bar + 3'd1;
                    r_bar_px  <= 16'd0;
                end else begin
                    r_bar_idx <= w_cur_bar;
                    r_bar_px  <= w_cur_px + 16'd1;
                end
            end
        end
    end

    assign vs_out     = r_vs;
    assign href_out   = r_href;
    assign data_out   = r_data;
    assign frame_done = r_done;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_dvp_pixel_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_dvp_pixel_tx
// Purpose  : Self-checking bench for dvp_pixel_tx using a frame-offset model.
// Revision : 1.0
// ============================================================================
module tb_dvp_pixel_tx;

    localparam int H_ACTIVE    = 8;
    localparam int V_ACTIVE    = 2;
    localparam int H_BLANK     = 4;
    localparam int VS_PULSE    = 3;
    localparam int V_FRONT     = 5;
    localparam int V_BACK      = 6;
    localparam int A0          = VS_PULSE + V_FRONT;
    localparam int LINE_PERIOD = 2 * H_ACTIVE + H_BLANK;
    localparam int FRAME       = VS_PULSE + V_FRONT + V_ACTIVE * 2 * H_ACTIVE
                                 + (V_ACTIVE - 1) * H_BLANK + V_BACK;

    logic        pclk_in     = 1'b0;
    logic        rst_n       = 1'b0;
    logic        enable      = 1'b0;
    logic        pattern_sel = 1'b1;
    logic [15:0] pix_data    = 16'h0000;
    logic        pix_valid   = 1'b0;
    logic        pix_ready;
    logic        vs_out;
    logic        href_out;
    logic [7:0]  data_out;
    logic        frame_done;
    logic        underrun;

    dvp_pixel_tx #(
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE),
        .H_BLANK  (H_BLANK),
        .VS_PULSE (VS_PULSE),
        .V_FRONT  (V_FRONT),
        .V_BACK   (V_BACK)
    ) dut (
        .pclk_in     (pclk_in),
        .rst_n       (rst_n),
        .enable      (enable),
        .pattern_sel (pattern_sel),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .vs_out      (vs_out),
        .href_out    (href_out),
        .data_out    (data_out),
        .frame_done  (frame_done),
        .underrun    (underrun)
    );

    always #5 pclk_in = ~pclk_in;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                              16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    logic [7:0] pat_line [16] = '{8'hFF, 8'hFF, 8'hFF, 8'hE0, 8'h07, 8'hFF, 8'h07, 8'hE0,
                                  8'hF8, 8'h1F, 8'hF8, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00};

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Byte index within the active line at frame offset t, or -1 outside href.
    function automatic int byte_index(input int t);
        for (int l = 0; l < V_ACTIVE; l++) begin
            int s;
            s = A0 + l * LINE_PERIOD;
            if (t >= s && t < s + 2 * H_ACTIVE) return t - s;
        end
        return -1;
    endfunction

    function automatic logic [15:0] bar_pixel(input int p);
        int k;
        k = p / (H_ACTIVE / 8);
        if (k > 7) k = 7;
        return bars[k];
    endfunction

    function automatic logic is_slot(input int pos, input logic pat);
        int b;
        if (pos < 0 || pat) return 1'b0;
        b = byte_index(pos + 1);
        return (b >= 0) && (b % 2 == 0);
    endfunction

    // Model: frame offset (-1 = idle), latched mode, current pixel, sticky underrun.
    int          m_pos   = -1;
    logic        m_pat   = 1'b0;
    logic [15:0] m_pix   = 16'h0000;
    logic        m_under = 1'b0;

    always @(posedge pclk_in or negedge rst_n) begin
        if (!rst_n) begin
            m_pos   = -1;
            m_pat   = 1'b0;
            m_pix   = 16'h0000;
            m_under = 1'b0;
        end else begin
            if (is_slot(m_pos, m_pat)) begin
                m_pix = pix_valid ? pix_data : 16'h0000;
                if (!pix_valid) m_under = 1'b1;
            end
            if (m_pos < 0 || m_pos == FRAME - 1) m_pos = enable ? 0 : -1;
            else m_pos++;
            if (m_pos == 0) m_pat = pattern_sel;
        end
    end

    // Per-cycle compare plus a small event log for the directed checks.
    int         cyc = 0, vs_rise_cyc = -1, done_cyc = -1, gap = -1, vs_len = 0;
    int         href_first_cyc = -1, byte_n = 0, href_run = 0, last_run = 0;
    logic       prev_vs = 1'b0, prev_href = 1'b0;
    logic [7:0] byte_log [32];

    always @(negedge pclk_in) begin
        int          b;
        logic [15:0] px;
        logic [7:0]  e_data;
        b      = (m_pos >= 0) ? byte_index(m_pos) : -1;
        e_data = 8'h00;
        if (b >= 0) begin
            px     = m_pat ? bar_pixel(b / 2) : m_pix;
            e_data = (b % 2 == 0) ? px[15:8] : px[7:0];
        end
        check("vs_out", int'(vs_out), int'(m_pos >= 0 && m_pos < VS_PULSE));
        check("href_out", int'(href_out), int'(b >= 0));
        check("data_out", int'(data_out), int'(e_data));
        check("frame_done", int'(frame_done), int'(m_pos == FRAME - 1));
        check("pix_ready", int'(pix_ready), int'(is_slot(m_pos, m_pat)));
        check("underrun", int'(underrun), int'(m_under));

        cyc++;
        if (vs_out && !prev_vs) begin
            if (done_cyc >= 0) gap = cyc - done_cyc;
            vs_rise_cyc = cyc;
            byte_n      = 0;
            href_first_cyc = -1;
        end
        if (vs_out) vs_len = prev_vs ? vs_len + 1 : 1;
        if (href_out) begin
            if (href_first_cyc < 0) href_first_cyc = cyc;
            if (byte_n < 32) byte_log[byte_n] = data_out;
            byte_n++;
            href_run++;
        end else if (prev_href) begin
            last_run = href_run;
            href_run = 0;
        end
        if (frame_done) done_cyc = cyc;
        prev_vs   = vs_out;
        prev_href = href_out;
    end

    // Upstream source: incrementing pixels, optional dropped slot per frame.
    int   seq = 0, slot = 0, drop_slot = -1, xfers = 0;
    logic feed_on = 1'b0, last_xfer = 1'b0;

    always begin
        @(negedge pclk_in);
        #1;
        if (last_xfer) begin
            seq++;
            xfers++;
        end
        if (vs_out) begin
            slot  = 0;
            xfers = 0;
        end
        pix_valid = feed_on && !(pix_ready && slot == drop_slot);
        pix_data  = 16'(32'h1234 + seq);
        last_xfer = pix_ready && pix_valid;
        if (pix_ready) slot++;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge pclk_in);
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!frame_done && k < limit) begin
            @(negedge pclk_in);
            k++;
        end
        if (!frame_done) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: no frame_done within %0d cycles", limit);
        end
        #1;
    endtask

    task automatic wait_href(input int limit);
        int k;
        k = 0;
        while (!href_out && k < limit) begin
            @(negedge pclk_in);
            k++;
        end
        if (!href_out) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_href: no href within %0d cycles", limit);
        end
    endtask

    initial begin
        wait_cycles(3);
        check("rst_vs", int'(vs_out), 0);
        check("rst_href", int'(href_out), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_ready", int'(pix_ready), 0);
        check("rst_done", int'(frame_done), 0);
        check("rst_underrun", int'(underrun), 0);
        #1 rst_n = 1'b1;
        wait_cycles(2);
        #1 enable = 1'b1;
        @(negedge pclk_in);
        #1 enable = 1'b0;

        // Single colour-bar frame.
        wait_done(80);
        check("pat_frame_len", done_cyc - vs_rise_cyc, 49);
        check("pat_vs_len", vs_len, 3);
        check("pat_href_delay", href_first_cyc - vs_rise_cyc, 8);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("pat_l0_b%0d", i), int'(byte_log[i]), int'(pat_line[i]));
            check($sformatf("pat_l1_b%0d", i), int'(byte_log[16 + i]), int'(pat_line[i]));
        end

        // Back-to-back stream frames.
        wait_cycles(3);
        #1;
        pattern_sel = 1'b0;
        feed_on     = 1'b1;
        enable      = 1'b1;
        wait_done(80);
        check("str_b0", int'(byte_log[0]), 8'h12);
        check("str_b1", int'(byte_log[1]), 8'h34);
        check("str_b2", int'(byte_log[2]), 8'h12);
        check("str_b3", int'(byte_log[3]), 8'h35);
        check("str_b31", int'(byte_log[31]), 8'h43);
        check("str_xfers", xfers, 16);
        check("str_underrun", int'(underrun), 0);
        drop_slot = 2;

        @(negedge pclk_in);
        wait_done(80);
        check("b2b_gap", gap, 1);
        check("drop_b2", int'(byte_log[2]), 8'h12);
        check("drop_b3", int'(byte_log[3]), 8'h45);
        check("drop_b4", int'(byte_log[4]), 8'h00);
        check("drop_b5", int'(byte_log[5]), 8'h00);
        check("drop_b6", int'(byte_log[6]), 8'h12);
        check("drop_b7", int'(byte_log[7]), 8'h46);
        check("drop_href_len", last_run, 16);
        check("drop_xfers", xfers, 15);
        check("drop_underrun", int'(underrun), 1);
        drop_slot = -1;

        // Enable removed mid-line: frame must still complete, then idle.
        @(negedge pclk_in);
        wait_href(80);
        #1 enable = 1'b0;
        wait_done(80);
        check("trunc_xfers", xfers, 16);
        check("trunc_href_len", last_run, 16);
        wait_cycles(6);
        #1;
        check("idle_vs", int'(vs_out), 0);
        check("idle_href", int'(href_out), 0);
        check("idle_data", int'(data_out), 0);
        check("idle_ready", int'(pix_ready), 0);
        check("idle_underrun_sticky", int'(underrun), 1);

        // Asynchronous reset in the middle of an active line.
        enable = 1'b1;
        wait_href(80);
        wait_cycles(3);
        #2 rst_n = 1'b0;
        #1;
        check("arst_vs", int'(vs_out), 0);
        check("arst_href", int'(href_out), 0);
        check("arst_data", int'(data_out), 0);
        check("arst_ready", int'(pix_ready), 0);
        check("arst_underrun", int'(underrun), 0);
        wait_cycles(2);
        #1 rst_n = 1'b1;
        wait_done(80);
        enable = 1'b0;
        check("fresh_frame_len", done_cyc - vs_rise_cyc, 49);
        check("fresh_xfers", xfers, 16);
        check("fresh_underrun", int'(underrun), 0);
        wait_cycles(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
